ga_generation_sequencer: RTL

Top-level control FSM for the genetic-algorithm core. It sequences the per-generation datapath phases (population load, fitness evaluation, selection, crossover, mutation) through a single start/done handshake and counts generations. It tracks the best chromosome seen on the evaluator's result stream. It drives `best_chromosome`, `best_fitness` and `ga_done` at the GA top level.

---
 rtl/ga_pkg.sv | 24 ++
 rtl/ga_best_tracker.sv | 73 +++++++
 rtl/ga_generation_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared types and sizing helpers for the GA generation sequencer.
package ga_pkg;

  typedef enum logic [2:0] {
    PH_INIT   = 3'd0,
    PH_EVAL   = 3'd1,
    PH_SELECT = 3'd2,
    PH_XOVER  = 3'd3,
    PH_MUTATE = 3'd4
  } ga_phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  // Generation counter width: must hold 0..max_gen inclusive.
  function automatic int gen_width(input int max_gen);
    return (max_gen < 1) ? 1 : $clog2(max_gen + 1);
  endfunction

endpackage

// File: rtl/ga_best_tracker.sv
// Best-chromosome tracker; with GA_EARLY_STOP_EN defined it also raises a sticky
// early-stop flag once an accepted fitness reaches TARGET.
module ga_best_tracker
  import ga_pkg::*;
#(
  parameter int            CW     = 8,
  parameter int            FW     = 10,
  parameter logic [FW-1:0] TARGET = {FW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  input  logic          fit_valid,
  input  logic [CW-1:0] fit_chrom,
  input  logic [FW-1:0] fit_value,
  output logic [CW-1:0] best_chrom,
  output logic [FW-1:0] best_fit,
  output logic          early_stop
);

  logic [CW-1:0] best_chrom_q, best_chrom_d;
  logic [FW-1:0] best_fit_q, best_fit_d;
  logic          accept;

  assign accept = enable && fit_valid;

  // Strict compare so a tie keeps the earlier entry.
  always_comb begin
    best_chrom_d = best_chrom_q;
    best_fit_d   = best_fit_q;
    if (clear) begin
      best_chrom_d = '0;
      best_fit_d   = '0;
    end else if (accept && (fit_value > best_fit_q)) begin
      best_chrom_d = fit_chrom;
      best_fit_d   = fit_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_chrom_q <= '0;
      best_fit_q   <= '0;
    end else begin
      best_chrom_q <= best_chrom_d;
      best_fit_q   <= best_fit_d;
    end
  end

  assign best_chrom = best_chrom_q;
  assign best_fit   = best_fit_q;

`ifdef GA_EARLY_STOP_EN
  logic stop_q, stop_d, hit;

  assign hit    = accept && (fit_value >= TARGET);
  assign stop_d = clear ? 1'b0 : (stop_q | hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stop_q <= 1'b0;
    else        stop_q <= stop_d;
  end

  // Include the live hit so a qualifying result beside the final phase_done counts.
  assign early_stop = stop_q | hit;
`else
  logic unused_target;
  assign unused_target = ^TARGET;
  assign early_stop    = 1'b0;
`endif

endmodule

// File: rtl/ga_generation_sequencer.sv
// GA per-generation phase sequencer with best-result tracking.
// Optional feature macro: GA_EARLY_STOP_EN (stop after the EVAL that reaches TARGET_FITNESS).
module ga_generation_sequencer
  import ga_pkg::*;
#(
  parameter int                       CHROMOSOME_WIDTH = 8,
  parameter int                       FITNESS_WIDTH    = 10,
  parameter int                       POPULATION_SIZE  = 16,
  parameter int                       MAX_GENERATIONS  = 100,
  parameter logic [FITNESS_WIDTH-1:0] TARGET_FITNESS   = 10'h3FF,
  localparam int                      GEN_W            = gen_width(MAX_GENERATIONS),
  localparam int                      IDX_W            = $clog2(POPULATION_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_ga,
  input  logic                        ga_abort,
  output logic                        phase_start,
  output logic [2:0]                  phase_sel,
  input  logic                        phase_done,
  input  logic                        fit_valid,
  input  logic [IDX_W-1:0]            fit_idx,
  input  logic [CHROMOSOME_WIDTH-1:0] fit_chrom,
  input  logic [FITNESS_WIDTH-1:0]    fit_value,
  output logic [CHROMOSOME_WIDTH-1:0] best_chromosome,
  output logic [FITNESS_WIDTH-1:0]    best_fitness,
  output logic [GEN_W-1:0]            gen_count,
  output logic                        ga_busy,
  output logic                        ga_done
);

  localparam logic [GEN_W-1:0] GEN_MAX = GEN_W'(MAX_GENERATIONS);

  logic [1:0]       rst_sync_q;
  logic             srst_n;
  seq_state_e       state_q, state_d;
  ga_phase_e        phase_q, phase_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             start_q, start_edge;
  logic             phase_start_q, phase_start_d;
  logic             clear_best, track_en, early_stop;
  logic             unused_idx;

  assign unused_idx = ^fit_idx;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign srst_n = rst_sync_q[1];

  assign start_edge = start_ga && !start_q;
  assign track_en   = (state_q == ST_WAIT) && (phase_q == PH_EVAL);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gen_d      = gen_q;
    clear_best = 1'b0;
    if (ga_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            clear_best = 1'b1;
            gen_d      = '0;
            phase_d    = PH_INIT;
            state_d    = ST_ISSUE;
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (phase_done) begin
            state_d = ST_ISSUE;
            unique case (phase_q)
              PH_INIT:   phase_d = PH_EVAL;
              PH_EVAL: begin
                if ((gen_q == GEN_MAX) || early_stop) state_d = ST_DONE;
                else                                  phase_d = PH_SELECT;
              end
              PH_SELECT: phase_d = PH_XOVER;
              PH_XOVER:  phase_d = PH_MUTATE;
              PH_MUTATE: begin
                phase_d = PH_EVAL;
                gen_d   = (gen_q == GEN_MAX) ? gen_q : gen_q + 1'b1;
              end
              default:   phase_d = PH_INIT;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobe is registered, so it lands one cycle after the ISSUE state.
  assign phase_start_d = (state_q == ST_ISSUE) && !ga_abort;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_INIT;
      gen_q         <= '0;
      start_q       <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      gen_q         <= gen_d;
      start_q       <= start_ga;
      phase_start_q <= phase_start_d;
    end
  end

  ga_best_tracker #(
    .CW     (CHROMOSOME_WIDTH),
    .FW     (FITNESS_WIDTH),
    .TARGET (TARGET_FITNESS)
  ) u_best (
    .clk        (clk),
    .rst_n      (srst_n),
    .clear      (clear_best),
    .enable     (track_en),
    .fit_valid  (fit_valid),
    .fit_chrom  (fit_chrom),
    .fit_value  (fit_value),
    .best_chrom (best_chromosome),
    .best_fit   (best_fitness),
    .early_stop (early_stop)
  );

  assign phase_start = phase_start_q;
  assign phase_sel   = phase_q;
  assign gen_count   = gen_q;
  assign ga_busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ga_done     = (state_q == ST_DONE);

endmodule
